// File: rtl/conv5x5_mac.sv
// conv5x5_mac: 5x5 int8 convolution stage behind the sliding-window line buffer.
// Tracks pixel position, keeps in-image windows only, MAC + bias, optional ReLU, rounding shift, int8 saturation.
module conv5x5_mac #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid_in,
    input  logic             sof,
    input  logic [199:0]     window,        // window[r][c] lives at bits (5*r+c)*8 +: 8
    input  logic             w_we,
    input  logic [4:0]       w_addr,
    input  logic [7:0]       w_data,
    input  logic             bias_we,
    input  logic [ACC_W-1:0] bias_data,
    input  logic             relu_en,
    output logic [7:0]       pix_out,
    output logic             pix_valid_out,
    output logic             frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE = CW'(1'b1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1'b1);
    localparam logic [CW-1:0] WIN_C   = CW'(3'd4);
    localparam logic [RW-1:0] WIN_R   = RW'(3'd4);
    localparam int RND_SH = (OUT_SHIFT > 0) ? (OUT_SHIFT - 1) : 0;
    localparam logic signed [ACC_W:0] RND    = (OUT_SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : '0;
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W-7){1'b0}}, 8'h7f};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W-7){1'b1}}, 8'h80};

    logic [CW-1:0] col_q, col_d, cur_col_s;
    logic [RW-1:0] row_q, row_d, cur_row_s;
    logic          win_ok_s;
    logic v0_q, v1_q, v2_q, v3_q, v4_q, v0_d, v1_d, v2_d, v3_d, v4_d;
    logic last0_q, last1_q, last2_q, last3_q, last4_q;
    logic last0_d, last1_d, last2_d, last3_d, last4_d;
    logic [24:0][7:0]        kern_q, kern_d;
    logic signed [ACC_W-1:0] bias_q, bias_d;
    logic signed [15:0]      prod_q [25];
    logic signed [15:0]      prod_d [25];
    logic signed [18:0]      rsum_q [5];
    logic signed [18:0]      rsum_d [5];
    logic signed [20:0]      tot_s;
    logic signed [ACC_W-1:0] acc_q, acc_d, relu_s;
    logic signed [ACC_W:0]   rnd_s, sh_s;
    logic [7:0]              sat_s, pix_out_q, pix_out_d;

    // Position of the pixel accepted this cycle, next counters and stage-0 flags.
    always_comb begin
        cur_col_s = col_q;
        cur_row_s = row_q;
        col_d     = col_q;
        row_d     = row_q;
        v0_d      = 1'b0;
        last0_d   = 1'b0;
        if (pix_valid_in && sof) begin
            cur_col_s = '0;
            cur_row_s = '0;
        end else begin
            cur_col_s = col_q;
            cur_row_s = row_q;
        end
        win_ok_s = (cur_col_s >= WIN_C) && (cur_row_s >= WIN_R);
        if (pix_valid_in) begin
            v0_d    = win_ok_s;
            last0_d = win_ok_s && (cur_col_s == COL_MAX) && (cur_row_s == ROW_MAX);
            if (cur_col_s == COL_MAX) begin
                col_d = '0;
                if (cur_row_s == ROW_MAX) begin
                    row_d = '0;
                end else begin
                    row_d = cur_row_s + ROW_ONE;
                end
            end else begin
                col_d = cur_col_s + COL_ONE;
                row_d = cur_row_s;
            end
        end else begin
            v0_d    = 1'b0;
            last0_d = 1'b0;
        end
    end

    // Coefficient registers; writes land at the write edge.
    always_comb begin
        kern_d = kern_q;
        bias_d = bias_q;
        for (int i = 0; i < 25; i++) begin
            if (w_we && (w_addr == 5'(i))) begin
                kern_d[i] = w_data;
            end else begin
                kern_d[i] = kern_q[i];
            end
        end
        if (bias_we) begin
            bias_d = bias_data;
        end else begin
            bias_d = bias_q;
        end
    end

    // Datapath: products, row sums, bias add, then ReLU / round / saturate.
    always_comb begin
        for (int i = 0; i < 25; i++) begin
            prod_d[i] = 16'($signed(window[i*8 +: 8])) * 16'($signed(kern_q[i]));
        end
        for (int r = 0; r < 5; r++) begin
            rsum_d[r] = '0;
            for (int c = 0; c < 5; c++) begin
                rsum_d[r] = rsum_d[r] + 19'(prod_q[r*5+c]);
            end
        end
        tot_s = '0;
        for (int r = 0; r < 5; r++) begin
            tot_s = tot_s + 21'(rsum_q[r]);
        end
        acc_d = ACC_W'(tot_s) + bias_q;
        if (relu_en && acc_q[ACC_W-1]) begin
            relu_s = '0;
        end else begin
            relu_s = acc_q;
        end
        rnd_s = (ACC_W+1)'(relu_s) + RND;
        sh_s  = rnd_s >>> OUT_SHIFT;
        if (sh_s > SAT_HI) begin
            sat_s = 8'h7f;
        end else if (sh_s < SAT_LO) begin
            sat_s = 8'h80;
        end else begin
            sat_s = sh_s[7:0];
        end
        if (v3_q) begin
            pix_out_d = sat_s;
        end else begin
            pix_out_d = pix_out_q;
        end
    end

    // Valid and end-of-frame tags travel alongside the data.
    always_comb begin
        v1_d    = v0_q;
        v2_d    = v1_q;
        v3_d    = v2_q;
        v4_d    = v3_q;
        last1_d = last0_q;
        last2_d = last1_q;
        last3_d = last2_q;
        last4_d = last3_q;
    end

    // State registers; reset drops every in-flight result and clears coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            last0_q   <= 1'b0;
            last1_q   <= 1'b0;
            last2_q   <= 1'b0;
            last3_q   <= 1'b0;
            last4_q   <= 1'b0;
            kern_q    <= '0;
            bias_q    <= '0;
            acc_q     <= '0;
            pix_out_q <= 8'h00;
            for (int i = 0; i < 25; i++) prod_q[i] <= '0;
            for (int r = 0; r < 5; r++) rsum_q[r] <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            v4_q      <= v4_d;
            last0_q   <= last0_d;
            last1_q   <= last1_d;
            last2_q   <= last2_d;
            last3_q   <= last3_d;
            last4_q   <= last4_d;
            kern_q    <= kern_d;
            bias_q    <= bias_d;
            acc_q     <= acc_d;
            pix_out_q <= pix_out_d;
            for (int i = 0; i < 25; i++) prod_q[i] <= prod_d[i];
            for (int r = 0; r < 5; r++) rsum_q[r] <= rsum_d[r];
        end
    end

    assign pix_out       = pix_out_q;
    assign pix_valid_out = v4_q;
    assign frame_done    = last4_q;

endmodule

// File: tb/tb_conv5x5_mac.sv
// Bench for conv5x5_mac: two instances (no shift / shift 8) share stimulus; a reference
// convolution pushes expected results into a scoreboard drained by a negedge monitor.
module tb_conv5x5_mac;
    localparam int W = 32;
    localparam int H = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pix_valid_in = 1'b0;
    logic         sof = 1'b0;
    logic [199:0] window = '0;
    logic         w_we = 1'b0;
    logic [4:0]   w_addr = 5'd0;
    logic [7:0]   w_data = 8'd0;
    logic         bias_we = 1'b0;
    logic [31:0]  bias_data = 32'd0;
    logic         relu_en = 1'b0;
    logic [7:0]   pix_out0, pix_out8;
    logic         pv0, pv8, fd0, fd8;

    conv5x5_mac #(.IMG_W(W), .IMG_H(H), .ACC_W(32), .OUT_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .pix_valid_in(pix_valid_in), .sof(sof), .window(window),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .bias_we(bias_we), .bias_data(bias_data),
        .relu_en(relu_en), .pix_out(pix_out0), .pix_valid_out(pv0), .frame_done(fd0));

    conv5x5_mac #(.IMG_W(W), .IMG_H(H), .ACC_W(32), .OUT_SHIFT(8)) u_dut8 (
        .clk(clk), .rst(rst), .pix_valid_in(pix_valid_in), .sof(sof), .window(window),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .bias_we(bias_we), .bias_data(bias_data),
        .relu_en(relu_en), .pix_out(pix_out8), .pix_valid_out(pv8), .frame_done(fd8));

    always #5 clk = ~clk;

    typedef struct {
        int e0;
        int e8;
        bit fd;
        int cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    bit     mon_en = 1'b0;
    int     last0 = 0;
    int     last8 = 0;
    int     n_out = 0;
    int     n_fd = 0;
    bit     grab = 1'b0;
    int     first_val = 0;
    int     mark_cyc = -1;
    int     mark_hit = -1;

    int     img [H][W];
    int     kmodel [25];
    longint bmodel = 0;
    int     mcol = 0;
    int     mrow = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Output stage as described: ReLU, round half up, arithmetic shift, clamp to int8.
    function automatic int post(input longint acc, input int sh);
        longint a;
        a = acc;
        if (relu_en && a < 0) a = 0;
        if (sh > 0) a = a + (longint'(1) << (sh - 1));
        a = a >>> sh;
        if (a > 127) a = 127;
        else if (a < -128) a = -128;
        return int'(a);
    endfunction

    function automatic longint conv_at(input int c, input int r);
        longint acc;
        acc = bmodel;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                acc += longint'(img[r-4+i][c-4+j]) * longint'(kmodel[i*5+j]);
        return acc;
    endfunction

    function automatic int pixval(input int mode, input int r, input int c);
        case (mode)
            0: return (r * 32 + c) & 127;
            1: return (r * 32 + c) & 63;
            3: return 127;
            4: return -128;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_s8", pv8, pv0);
            if (pv0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pix_out %0d, expected no output (cycle %0d)",
                             $signed(pix_out0), cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pix_out_s0", $signed(pix_out0), e.e0);
                    chk("pix_out_s8", $signed(pix_out8), e.e8);
                    chk("frame_done_s0", fd0, e.fd);
                    chk("frame_done_s8", fd8, e.fd);
                    chk("latency", cyc, e.cyc + 4);
                    last0 = e.e0;
                    last8 = e.e8;
                end
                n_out++;
                if (fd0) n_fd++;
                if (grab) begin
                    first_val = $signed(pix_out0);
                    grab = 1'b0;
                end
                if (mark_cyc >= 0 && mark_hit < 0 && cyc > mark_cyc + 4) mark_hit = cyc;
            end else begin
                chk("hold_s0", $signed(pix_out0), last0);
                chk("hold_s8", $signed(pix_out8), last8);
                chk("frame_done_idle", fd0, 1'b0);
            end
        end
    end

    // One clock of stimulus; the model mirrors what the image/kernel state is after that edge.
    task automatic step(input bit v, input bit s, input int px, input bit we, input int wa, input int wd);
        int c;
        int r;
        exp_t e;
        pix_valid_in = v;
        sof          = s;
        w_we         = we;
        w_addr       = 5'(wa);
        w_data       = 8'(wd);
        @(posedge clk);
        #1;
        if (we && wa < 25) kmodel[wa] = wd;
        if (v) begin
            c = s ? 0 : mcol;
            r = s ? 0 : mrow;
            img[r][c] = px;
            if (c >= 4 && r >= 4) begin
                longint acc;
                acc   = conv_at(c, r);
                e.e0  = post(acc, 0);
                e.e8  = post(acc, 8);
                e.fd  = (c == W-1) && (r == H-1);
                e.cyc = cyc;
                sb.push_back(e);
            end
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    window[(i*5+j)*8 +: 8] = (c >= 4 && r >= 4) ? 8'(img[r-4+i][c-4+j]) : 8'd0;
            mcol = (c == W-1) ? 0 : c + 1;
            mrow = (c == W-1) ? ((r == H-1) ? 0 : r + 1) : r;
        end
        pix_valid_in = 1'b0;
        sof          = 1'b0;
        w_we         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic set_bias(input longint val);
        idle(6);
        bias_we   = 1'b1;
        bias_data = 32'(val);
        @(posedge clk);
        #1;
        bmodel  = val;
        bias_we = 1'b0;
    endtask

    task automatic write_kernel(input int mode);
        for (int i = 0; i < 25; i++) begin
            int v;
            case (mode)
                0: v = (i == 12) ? 1 : 0;
                1: v = 1;
                2: v = 0;
                default: v = int'($urandom_range(255)) - 128;
            endcase
            step(1'b0, 1'b0, 0, 1'b1, i, v);
        end
    endtask

    // Feeds n accepted pixels with pct% valid density; optional centre-tap writes at given pixel indices.
    task automatic run_pixels(input bit first_sof, input int n, input int mode, input int pct,
                              input bit mark, input int wa_i, input int wa_v, input int wb_i, input int wb_v);
        int k;
        k = 0;
        while (k < n) begin
            if ($urandom_range(99) < pct) begin
                bit s;
                int c;
                int r;
                s = first_sof && (k == 0);
                c = s ? 0 : mcol;
                r = s ? 0 : mrow;
                step(1'b1, s, pixval(mode, r, c), (k == wa_i) || (k == wb_i), 12, (k == wa_i) ? wa_v : wb_v);
                if (mark && k == 0) begin
                    mark_cyc = cyc;
                    mark_hit = -1;
                end
                k++;
            end else begin
                step(1'b0, 1'b0, 0, 1'b0, 0, 0);
            end
        end
    endtask

    task automatic do_reset();
        pix_valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        last0 = 0;
        last8 = 0;
        mcol = 0;
        mrow = 0;
        bmodel = 0;
        for (int i = 0; i < 25; i++) kmodel[i] = 0;
        rst = 1'b0;
    endtask

    initial begin
        int snap;
        int snapfd;
        for (int i = 0; i < 25; i++) kmodel[i] = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_out", pix_out0, 8'd0);
        chk("rst_valid", pv0, 1'b0);
        chk("rst_frame_done", fd0, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Identity kernel over a full frame
        write_kernel(0);
        snap = n_out; snapfd = n_fd; grab = 1'b1;
        run_pixels(1'b1, W*H, 0, 100, 1'b0, -1, 0, -1, 0);
        idle(8);
        chk("id_first_out", first_val, 66);
        chk("id_out_count", n_out - snap, 784);
        chk("id_frame_done_count", n_fd - snapfd, 1);

        // Saturation, with and without ReLU
        write_kernel(1);
        run_pixels(1'b1, W*H, 3, 100, 1'b0, -1, 0, -1, 0);
        run_pixels(1'b1, W*H, 4, 100, 1'b0, -1, 0, -1, 0);
        idle(6);
        relu_en = 1'b1;
        run_pixels(1'b1, W*H, 4, 100, 1'b0, -1, 0, -1, 0);
        idle(6);
        relu_en = 1'b0;

        // Rounding at the half-LSB boundary
        write_kernel(2);
        set_bias(128);  run_pixels(1'b1, 140, 2, 100, 1'b0, -1, 0, -1, 0);
        set_bias(127);  run_pixels(1'b1, 140, 2, 100, 1'b0, -1, 0, -1, 0);
        set_bias(-129); run_pixels(1'b1, 140, 2, 100, 1'b0, -1, 0, -1, 0);
        set_bias(-128); run_pixels(1'b1, 140, 2, 100, 1'b0, -1, 0, -1, 0);
        set_bias(0);

        // Gapped input
        write_kernel(0);
        snap = n_out; grab = 1'b1;
        run_pixels(1'b1, W*H, 0, 50, 1'b0, -1, 0, -1, 0);
        idle(8);
        chk("gap_first_out", first_val, 66);
        chk("gap_out_count", n_out - snap, 784);

        // Mid-frame sof restart, then reset after 500 pixels
        run_pixels(1'b1, 299, 0, 100, 1'b0, -1, 0, -1, 0);
        run_pixels(1'b1, 141, 0, 100, 1'b1, -1, 0, -1, 0);
        chk("sof_restart_latency", mark_hit - mark_cyc, 136);
        mark_cyc = -1;
        run_pixels(1'b0, 359, 0, 100, 1'b0, -1, 0, -1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_quiet", pv0, 1'b0);
        end
        write_kernel(0);
        snap = n_out; snapfd = n_fd;
        run_pixels(1'b1, W*H, 0, 100, 1'b0, -1, 0, -1, 0);
        idle(8);
        chk("restart_out_count", n_out - snap, 784);
        chk("restart_frame_done_count", n_fd - snapfd, 1);

        // Coefficient write timing relative to the S0 edge
        run_pixels(1'b1, W*H, 1, 100, 1'b0, 330, 2, 651, 1);
        idle(8);

        // Random kernel, bias, ReLU and pixels with gaps
        for (int t = 0; t < 2; t++) begin
            write_kernel(3);
            set_bias(longint'($urandom_range(2097152)) - 1048576);
            relu_en = 1'($urandom_range(1));
            idle(2);
            run_pixels(1'b1, W*H, 2, 70, 1'b0, -1, 0, -1, 0);
            idle(8);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
